// File: rtl/ucq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ucq_pkg
// Description : Shared literal type and sizing constants for the mstack to
//               UCQ_out broadcast path and its per-engine queues.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef NUM_ENGINE
`define NUM_ENGINE 2
`endif

`ifndef UCQ_SIZE
`define UCQ_SIZE 4
`endif

`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 7
`endif

package ucq_pkg;

    // Literal width: bit indices 0..LIT_IDX_MAX.
    localparam int c_lit_w      = `LIT_IDX_MAX + 1;
    localparam int c_num_engine = `NUM_ENGINE;
    localparam int c_ucq_size   = `UCQ_SIZE;

    typedef logic [c_lit_w-1:0] lit_t;

endpackage : ucq_pkg

`default_nettype wire

// File: rtl/ucq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ucq_fifo
// Description : Single-engine literal FIFO. Flags are registered from the
//               next-state occupancy count; head is read combinationally and
//               forced to zero while empty.
// Ports       : clk, rst (sync, active-high), flush (clears contents),
//               push/din (write), pop (consume head), dout (head literal),
//               empty/full (registered flags), ovf (push seen while full).
// Revision    : 1.0 - initial release
// ============================================================================

module ucq_fifo
    import ucq_pkg::*;
#(
    parameter int DEPTH = c_ucq_size,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  lit_t din,
    output lit_t dout,
    output logic empty,
    output logic full,
    output logic ovf
);

    localparam logic [PTR_W:0] c_full_cnt = (PTR_W + 1)'(DEPTH);

    lit_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_empty;
    logic             r_full;

    logic [PTR_W:0]   w_count_nxt;
    logic             w_push_ok;
    logic             w_pop_ok;

    // A push into a full queue is dropped (and reported) so stored data is
    // never overwritten; a pop on an empty queue is silently ignored.
    assign w_push_ok = push && !r_full;
    assign w_pop_ok  = pop && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_full_cnt);
        end
    end

    // Data array is not reset; stale entries are masked by the empty flag.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_empty ? '0 : r_mem[r_rd_ptr];
    assign empty = r_empty;
    assign full  = r_full;
    assign ovf   = push && r_full;

endmodule : ucq_fifo

`default_nettype wire

// File: rtl/ucq_out_bcast.sv
`default_nettype none
// ============================================================================
// Module      : ucq_out_bcast
// Description : Replicates each literal popped from the arbiter mstack into
//               one private FIFO per BCP engine. Any full engine queue stalls
//               the broadcast to all engines.
// Ports       : clk, rst (sync, active-high)
//               mstack2ucq_valid/lit : mstack head literal
//               ucq2mstack_full      : per-engine full, mstack pops when all 0
//               flush                : discard all queued literals
//               eng_pop/eng_lit/eng_empty : per-engine consume side
//               ovf_err              : sticky push-into-full indication
// Revision    : 1.0 - initial release
// ============================================================================

module ucq_out_bcast
    import ucq_pkg::*;
#(
    parameter int NUM_ENG = `NUM_ENGINE,
    parameter int DEPTH   = `UCQ_SIZE,
    parameter int PTR_W   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mstack2ucq_valid,
    input  lit_t                       mstack2ucq_lit,
    output logic [NUM_ENG-1:0]         ucq2mstack_full,
    input  logic                       flush,
    input  logic [NUM_ENG-1:0]         eng_pop,
    output logic [NUM_ENG*c_lit_w-1:0] eng_lit,
    output logic [NUM_ENG-1:0]         eng_empty,
    output logic                       ovf_err
);

    logic [NUM_ENG-1:0] w_full;
    logic [NUM_ENG-1:0] w_empty;
    logic [NUM_ENG-1:0] w_ovf;
    lit_t               w_lit [NUM_ENG];
    logic               w_accept;
    logic               r_ovf_err;

    // Must mirror the mstack pop rule exactly: a literal leaves the mstack
    // iff it is written into every engine queue.
    assign w_accept = mstack2ucq_valid && !(|w_full) && !flush;

    generate
        for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_eng
            ucq_fifo #(
                .DEPTH (DEPTH),
                .PTR_W (PTR_W)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .flush (flush),
                .push  (w_accept),
                .pop   (eng_pop[gi]),
                .din   (mstack2ucq_lit),
                .dout  (w_lit[gi]),
                .empty (w_empty[gi]),
                .full  (w_full[gi]),
                .ovf   (w_ovf[gi])
            );

            assign eng_lit[gi*c_lit_w +: c_lit_w] = w_lit[gi];
        end
    endgenerate

    // Sticky: only rst clears it, flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
        end else if (|w_ovf) begin
            r_ovf_err <= 1'b1;
        end
    end

    assign ucq2mstack_full = w_full;
    assign eng_empty       = w_empty;
    assign ovf_err         = r_ovf_err;

endmodule : ucq_out_bcast

`default_nettype wire

// File: tb/tb_ucq_out_bcast.sv
`default_nettype none
// ============================================================================
// Module      : tb_ucq_out_bcast
// Description : Self-checking bench for ucq_out_bcast (2 engines, depth 4).
//               Directed vector table, corner-case sequences and random
//               traffic, all compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_ucq_out_bcast;
    import ucq_pkg::*;

    localparam int NE = 2;
    localparam int DP = 4;
    localparam int LW = c_lit_w;

    logic             clk = 1'b0;
    logic             rst;
    logic             mstack2ucq_valid;
    lit_t             mstack2ucq_lit;
    logic [NE-1:0]    ucq2mstack_full;
    logic             flush;
    logic [NE-1:0]    eng_pop;
    logic [NE*LW-1:0] eng_lit;
    logic [NE-1:0]    eng_empty;
    logic             ovf_err;

    always #5 clk = ~clk;

    ucq_out_bcast #(
        .NUM_ENG (NE),
        .DEPTH   (DP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mstack2ucq_valid (mstack2ucq_valid),
        .mstack2ucq_lit   (mstack2ucq_lit),
        .ucq2mstack_full  (ucq2mstack_full),
        .flush            (flush),
        .eng_pop          (eng_pop),
        .eng_lit          (eng_lit),
        .eng_empty        (eng_empty),
        .ovf_err          (ovf_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one literal queue per engine plus sticky overflow.
    lit_t mq [NE][$];
    logic m_ovf = 1'b0;

    typedef struct {
        logic       r;
        logic       v;
        lit_t       l;
        logic       f;
        logic [1:0] p;
        logic [1:0] e_empty;
        logic [1:0] e_full;
        lit_t       e_l0;
        lit_t       e_l1;
    } vec_t;

    vec_t tv [13];

    function automatic vec_t mk(logic r, logic v, lit_t l, logic f, logic [1:0] p,
                                logic [1:0] ee, logic [1:0] ef, lit_t l0, lit_t l1);
        vec_t t;
        t.r = r; t.v = v; t.l = l; t.f = f; t.p = p;
        t.e_empty = ee; t.e_full = ef; t.e_l0 = l0; t.e_l1 = l1;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic lit_t dut_lit(int i);
        return eng_lit[i*LW +: LW];
    endfunction

    task automatic cmp_model(input string tag);
        logic [NE-1:0] ee;
        logic [NE-1:0] ef;
        for (int i = 0; i < NE; i++) begin
            ee[i] = (mq[i].size() == 0);
            ef[i] = (mq[i].size() == DP);
            chk($sformatf("%s_lit%0d", tag, i), 32'(dut_lit(i)),
                32'((mq[i].size() != 0) ? mq[i][0] : lit_t'(0)));
        end
        chk({tag, "_empty"}, 32'(eng_empty), 32'(ee));
        chk({tag, "_full"}, 32'(ucq2mstack_full), 32'(ef));
        chk({tag, "_ovf"}, 32'(ovf_err), 32'(m_ovf));
    endtask

    // One clock: drive inputs, advance the model on the edge, sample 1 ns later.
    // frc overrides the accept path to create a push the real path never makes.
    task automatic step(input logic r, input logic v, input lit_t l, input logic f,
                        input logic [NE-1:0] p, input logic frc, input string tag);
        logic [NE-1:0] pre_full;
        logic          acc;
        for (int i = 0; i < NE; i++) pre_full[i] = (mq[i].size() == DP);
        acc = frc ? 1'b1 : (v && !(|pre_full) && !f);
        rst = r; mstack2ucq_valid = v; mstack2ucq_lit = l; flush = f; eng_pop = p;
        if (frc) force dut.w_accept = 1'b1;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < NE; i++) mq[i].delete();
            m_ovf = 1'b0;
        end else if (f) begin
            for (int i = 0; i < NE; i++) mq[i].delete();
        end else begin
            for (int i = 0; i < NE; i++) begin
                if (p[i] && mq[i].size() != 0) void'(mq[i].pop_front());
                if (acc) begin
                    if (pre_full[i]) m_ovf = 1'b1;
                    else             mq[i].push_back(l);
                end
            end
        end
        #1;
        if (frc) release dut.w_accept;
        cmp_model(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mstack2ucq_valid = 1'b0; mstack2ucq_lit = '0;
        flush = 1'b0; eng_pop = '0;

        // reset with valid high, independent drain, backpressure, flush, idle pops
        tv[0]  = mk(1'b1, 1'b1, 8'h55, 1'b0, 2'b00, 2'b11, 2'b00, 8'h00, 8'h00);
        tv[1]  = mk(1'b1, 1'b1, 8'h55, 1'b0, 2'b00, 2'b11, 2'b00, 8'h00, 8'h00);
        tv[2]  = mk(1'b0, 1'b1, 8'h02, 1'b0, 2'b00, 2'b00, 2'b00, 8'h02, 8'h02);
        tv[3]  = mk(1'b0, 1'b1, 8'h04, 1'b0, 2'b01, 2'b00, 2'b00, 8'h04, 8'h02);
        tv[4]  = mk(1'b0, 1'b1, 8'h06, 1'b0, 2'b01, 2'b00, 2'b00, 8'h06, 8'h02);
        tv[5]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 2'b01, 2'b00, 8'h00, 8'h02);
        tv[6]  = mk(1'b0, 1'b1, 8'h08, 1'b0, 2'b00, 2'b00, 2'b10, 8'h08, 8'h02);
        tv[7]  = mk(1'b0, 1'b1, 8'h0A, 1'b0, 2'b01, 2'b01, 2'b10, 8'h00, 8'h02);
        tv[8]  = mk(1'b0, 1'b1, 8'h0A, 1'b0, 2'b10, 2'b01, 2'b00, 8'h00, 8'h04);
        tv[9]  = mk(1'b0, 1'b1, 8'h0A, 1'b0, 2'b00, 2'b00, 2'b10, 8'h0A, 8'h04);
        tv[10] = mk(1'b0, 1'b1, 8'h0C, 1'b1, 2'b11, 2'b11, 2'b00, 8'h00, 8'h00);
        tv[11] = mk(1'b0, 1'b0, 8'h00, 1'b0, 2'b11, 2'b11, 2'b00, 8'h00, 8'h00);
        tv[12] = mk(1'b0, 1'b0, 8'h00, 1'b0, 2'b11, 2'b11, 2'b00, 8'h00, 8'h00);

        for (int k = 0; k < 13; k++) begin
            step(tv[k].r, tv[k].v, tv[k].l, tv[k].f, tv[k].p, 1'b0, $sformatf("tv%0d", k));
            chk($sformatf("tv%0d_tbl_empty", k), 32'(eng_empty), 32'(tv[k].e_empty));
            chk($sformatf("tv%0d_tbl_full", k), 32'(ucq2mstack_full), 32'(tv[k].e_full));
            chk($sformatf("tv%0d_tbl_l0", k), 32'(dut_lit(0)), 32'(tv[k].e_l0));
            chk($sformatf("tv%0d_tbl_l1", k), 32'(dut_lit(1)), 32'(tv[k].e_l1));
        end

        // Wrap-around: 10 literals streamed through depth-4 queues in order.
        step(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, "wrap_rst");
        step(1'b0, 1'b1, 8'h10, 1'b0, 2'b00, 1'b0, "wrap_fill");
        for (int k = 1; k < 10; k++) begin
            chk($sformatf("wrap_head0_%0d", k), 32'(dut_lit(0)), 32'(8'h10 + k - 1));
            chk($sformatf("wrap_head1_%0d", k), 32'(dut_lit(1)), 32'(8'h10 + k - 1));
            step(1'b0, 1'b1, lit_t'(8'h10 + k), 1'b0, 2'b11, 1'b0, $sformatf("wrap%0d", k));
            chk($sformatf("wrap_noempty_%0d", k), 32'(eng_empty), 32'(2'b00));
        end
        chk("wrap_last", 32'(dut_lit(0)), 32'(8'h19));
        step(1'b0, 1'b0, 8'h00, 1'b0, 2'b11, 1'b0, "wrap_drain");

        // Illegal pops on empty queues.
        for (int k = 0; k < 5; k++)
            step(1'b0, 1'b0, 8'h00, 1'b0, 2'b11, 1'b0, "idle_pop");
        step(1'b0, 1'b1, 8'h33, 1'b0, 2'b00, 1'b0, "after_idle");

        // Overflow: fill both queues, then force a push past full.
        step(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, "ovf_rst");
        for (int k = 0; k < DP; k++)
            step(1'b0, 1'b1, lit_t'(8'h40 + k), 1'b0, 2'b00, 1'b0, "ovf_fill");
        step(1'b0, 1'b1, 8'h4F, 1'b0, 2'b00, 1'b1, "ovf_force");
        chk("ovf_set", 32'(ovf_err), 32'(1));
        step(1'b0, 1'b1, 8'h50, 1'b1, 2'b11, 1'b0, "ovf_flush");
        step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, "ovf_hold");
        chk("ovf_sticky", 32'(ovf_err), 32'(1));
        step(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, "ovf_clr");
        chk("ovf_cleared", 32'(ovf_err), 32'(0));

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) != 0),
                 lit_t'($urandom),
                 ($urandom_range(0, 15) == 0),
                 NE'($urandom),
                 1'b0, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ucq_out_bcast

`default_nettype wire
